divide_signed: RTL and testbench
================================

Name: divide_signed

Overview:
- Multi-cycle signed divider; the inverse operation of the signed multiply-add slice.
- Recovers a quotient and remainder from a wide multiply-add product (P, 48 bits) and a 16-bit divisor.
- Used for gain normalisation and scaling checks in the Ch2 arithmetic chain.
- Radix-2 non-restoring/restoring iteration: one quotient bit per enabled clock, start/busy/done handshake.

Parameters:
- DIVIDEND_W, 48, width of the two's-complement dividend and quotient; must be >= DIVISOR_W.
- DIVISOR_W, 16, width of the two's-complement divisor and remainder.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DIVIDEND_W.

Ports:
- clk  in  1  single clock; all logic is clocked on the rising edge.
- SCLR  in  1  synchronous active-high reset; overrides CE.
- CE  in  1  clock enable; when low, all state, counter and outputs hold.
- start  in  1  request; sampled only in IDLE with CE=1.
- DIVIDEND  in  DIVIDEND_W  signed dividend; captured on the accepting edge.
- DIVISOR  in  DIVISOR_W  signed divisor; captured on the accepting edge.
- busy  out  1  high from the accepting edge until the done edge.
- done  out  1  one-cycle pulse; Q, R, DIV0 and OVF are valid from this edge.
- Q  out  DIVIDEND_W  signed quotient, truncated toward zero.
- R  out  DIVISOR_W  signed remainder; takes the sign of the dividend; |R| < |DIVISOR|.
- DIV0  out  1  divisor was zero.
- OVF  out  1  dividend was -2^(DIVIDEND_W-1) and divisor was -1.

Behaviour:
- Reset: SCLR=1 at an edge forces state IDLE.
  - busy, done, DIV0 and OVF are 0; Q and R are 0.
  - This holds regardless of CE or start, including mid-operation. An aborted operation never produces done.
- All edges below are CE=1 edges. CE=0 freezes the FSM, counter, internal registers and outputs.
  - done, if high, stays high while CE=0 and clears at the next enabled edge.
- IDLE:
  - start=1 at the edge: capture |DIVIDEND|, |DIVISOR| and both sign bits.
  - Flag the zero-divisor and overflow cases, clear the counter, set busy=1, go to RUN. This is edge 0.
  - start while busy is ignored, not queued.
- RUN:
  - Each edge shifts the partial remainder left by one and brings in the next dividend magnitude bit, MSB first.
  - Trial-subtract |DIVISOR|; the quotient bit is 1 if the result is non-negative.
  - After DIVIDEND_W iterations (edges 1..DIVIDEND_W), go to FIX.
  - Magnitude arithmetic is DIVISOR_W+1 bits wide, so |DIVISOR| = 2^(DIVISOR_W-1) is handled.
- FIX, at edge DIVIDEND_W+1:
  - Q = negated magnitude quotient if the signs differ.
  - R = negated magnitude remainder if the dividend is negative.
  - Register Q, R, DIV0 and OVF; done=1, busy=0; return to IDLE.
- Latency: done is asserted exactly DIVIDEND_W+1 enabled edges after the accepting edge (49 for the defaults).
  - Throughput: a start held high during the done cycle is accepted on the next enabled edge, giving one op per DIVIDEND_W+2 cycles.
- DIV0 case (DIVISOR=0): same latency; Q = all ones (-1), R = 0, DIV0=1, OVF=0.
- OVF case (-2^(DIVIDEND_W-1) / -1): same latency; Q = 0x8000_0000_0000 (wrapped), R = 0, OVF=1, DIV0=0.
- Q, R and the flags hold their last values until the next done or SCLR.

Test Plan:
- Basic case: DIVIDEND=100, DIVISOR=7, start on edge 0 -> done on edge 49 only, busy high on edges 0-48; Q=14, R=2, DIV0=OVF=0.
- Sign cases:
  - -100/7 -> Q=0xFFFF_FFFF_FFF2, R=0xFFFE.
  - 100/-7 -> Q=0xFFFF_FFFF_FFF2, R=0x0002.
  - -100/-7 -> Q=14, R=0xFFFE.
  - 0x7FFF_FFFF_FFFF / -32768 -> Q=0xFFFF_0000_0001 (-(2^32-1)), R=0x7FFF (32767).
- Exceptions:
  - 12345/0 -> done at edge 49, Q=0xFFFF_FFFF_FFFF, R=0, DIV0=1.
  - 0x8000_0000_0000 / 0xFFFF -> Q=0x8000_0000_0000, R=0, OVF=1.
- Stall and ignored start: 100/7 with CE=0 for 5 cycles during RUN, and start pulsed with new operands while busy -> done at edge 54; result still Q=14, R=2; only one done.
- Abort: SCLR=1 at edge 20 of an operation -> busy=0, Q=R=0 from that edge, no done. A new start for 1000/-3 on the next edge -> Q=-333 (0xFFFF_FFFF_FEB3), R=1, 49 edges later.
- Back-to-back, using a random model: start held high continuously for 1000 random signed operand pairs -> each done spaced exactly 50 cycles apart; Q*DIVISOR+R = DIVIDEND, |R| < |DIVISOR|, and sign(R) = sign(DIVIDEND) or R=0, checked against the reference model.

Source files
------------

// File: rtl/divide_signed.sv
// Multi-cycle radix-2 restoring signed divider: one quotient bit per enabled clock,
// magnitudes iterated, signs applied in a final fix-up cycle.
module divide_signed #(
  parameter int DIVIDEND_W = 48,
  parameter int DIVISOR_W  = 16,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  SCLR,
  input  logic                  CE,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] DIVIDEND,
  input  logic [DIVISOR_W-1:0]  DIVISOR,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  DIV0,
  output logic                  OVF,
  output logic [1:0]            dbg_state
);

  localparam int NW = DIVIDEND_W;
  localparam int DW = DIVISOR_W;

  // Handshake: start is accepted only at a CE=1 edge in IDLE; busy stays high
  // from that edge until the done edge; done is a one-enabled-cycle pulse and
  // Q/R/DIV0/OVF are valid from it until the next done or SCLR.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [NW-1:0]   qshift;   // dividend magnitude shifts out, quotient bits shift in
  logic [DW-1:0]   rem;
  logic [DW:0]     dsr_mag;
  logic            sign_n, sign_d, div0_r, ovf_r;

  logic [NW-1:0]   n_mag;
  logic [DW:0]     d_mag;
  logic [DW:0]     shifted;
  logic            qbit;
  logic            last_iter;

  always_comb begin
    n_mag     = DIVIDEND[NW-1] ? -DIVIDEND : DIVIDEND;
    d_mag     = {1'b0, (DIVISOR[DW-1] ? -DIVISOR : DIVISOR)};
    shifted   = {rem, qshift[NW-1]};
    qbit      = (shifted >= dsr_mag);
    last_iter = (cnt == CNT_W'(NW - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (SCLR) state <= S_IDLE;
    else if (CE) state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (SCLR) begin
      done    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      DIV0    <= 1'b0;
      OVF     <= 1'b0;
      cnt     <= '0;
      qshift  <= '0;
      rem     <= '0;
      dsr_mag <= '0;
      sign_n  <= 1'b0;
      sign_d  <= 1'b0;
      div0_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (CE) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            qshift  <= n_mag;
            dsr_mag <= d_mag;
            rem     <= '0;
            sign_n  <= DIVIDEND[NW-1];
            sign_d  <= DIVISOR[DW-1];
            div0_r  <= (DIVISOR == '0);
            ovf_r   <= (DIVIDEND == {1'b1, {(NW-1){1'b0}}}) && (DIVISOR == '1);
            cnt     <= '0;
          end
        end
        S_RUN: begin
          qshift <= {qshift[NW-2:0], qbit};
          rem    <= qbit ? DW'(shifted - dsr_mag) : shifted[DW-1:0];
          cnt    <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          done <= 1'b1;
          DIV0 <= div0_r;
          OVF  <= ovf_r;
          // The overflow case falls out naturally: magnitude 2^(NW-1), no negation.
          if (div0_r) begin
            Q <= '1;
            R <= '0;
          end else begin
            Q <= (sign_n ^ sign_d) ? -qshift : qshift;
            R <= sign_n ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_divide_signed.sv
// Directed and back-to-back random bench for divide_signed; expected results are
// queued at issue time and checked by an independent done monitor.
module tb_divide_signed;

  logic        clk = 1'b0;
  logic        SCLR, CE, start;
  logic [47:0] DIVIDEND;
  logic [15:0] DIVISOR;
  logic        busy, done, DIV0, OVF;
  logic [47:0] Q;
  logic [15:0] R;
  logic [1:0]  dbg_state;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        ce_s;
  logic [65:0] exp_q[$];
  int          cyc_q[$];
  logic [65:0] m_e;
  int          m_c;

  always #5 clk = ~clk;

  divide_signed dut (
    .clk(clk), .SCLR(SCLR), .CE(CE), .start(start),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .busy(busy), .done(done), .Q(Q), .R(R), .DIV0(DIV0), .OVF(OVF),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [47:0] n, input logic [15:0] d,
                       input logic [65:0] e, input int lat);
    DIVIDEND = n;
    DIVISOR  = d;
    start    = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + lat);
  endtask

  function automatic logic [65:0] model(input logic [47:0] n, input logic [15:0] d);
    longint sn, sd, q, r;
    if (d == 16'h0) return {48'hFFFF_FFFF_FFFF, 16'h0, 2'b10};
    if (n == 48'h8000_0000_0000 && d == 16'hFFFF) return {n, 16'h0, 2'b01};
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    q  = sn / sd;
    r  = sn % sd;
    return {q[47:0], r[15:0], 2'b00};
  endfunction

  // Monitor: a new done pulse is one seen right after an enabled edge.
  always @(posedge clk) begin
    ce_s = CE;
    cyc++;
    #1;
    if (done && ce_s) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: cycle %0d with no pending op", cyc);
      end else begin
        m_e = exp_q.pop_front();
        m_c = cyc_q.pop_front();
        chk("done_cycle", 66'(cyc), 66'(m_c));
        chk("result", {Q, R, DIV0, OVF}, m_e);
      end
    end else if (cyc_q.size() > 0 && cyc > cyc_q[0]) begin
      total++;
      bad++;
      $display("FAIL missing_done: cycle %0d expected done at %0d", cyc, cyc_q[0]);
      m_e = exp_q.pop_front();
      m_c = cyc_q.pop_front();
    end
  end

  logic [47:0] tn[5];
  logic [15:0] td[5];
  logic [65:0] te[5];
  logic [63:0] r64;
  logic [47:0] rn;
  logic [15:0] rd;

  initial begin
    SCLR = 1'b1; CE = 1'b1; start = 1'b1;
    DIVIDEND = 48'd100; DIVISOR = 16'd7;
    repeat (3) tick();
    chk("reset_outs", {46'h0, busy, done, DIV0, OVF, Q, R}, 66'h0);
    chk("reset_state", 66'(dbg_state), 66'h0);
    SCLR = 1'b0; start = 1'b0;
    tick();

    // Basic case with busy window checks
    issue(48'd100, 16'd7, {48'd14, 16'd2, 2'b00}, 49);
    chk("busy_edge0", 66'(busy), 66'h1);
    repeat (48) tick();
    chk("busy_edge48", 66'({busy, done}), 66'h2);
    tick();
    chk("busy_edge49", 66'(busy), 66'h0);
    tick();
    chk("done_pulse_clear", 66'(done), 66'h0);

    // Sign and exception table
    tn[0] = 48'hFFFF_FFFF_FF9C; td[0] = 16'd7;    te[0] = {48'hFFFF_FFFF_FFF2, 16'hFFFE, 2'b00};
    tn[1] = 48'd100;            td[1] = 16'hFFF9; te[1] = {48'hFFFF_FFFF_FFF2, 16'h0002, 2'b00};
    tn[2] = 48'hFFFF_FFFF_FF9C; td[2] = 16'hFFF9; te[2] = {48'd14, 16'hFFFE, 2'b00};
    tn[3] = 48'h7FFF_FFFF_FFFF; td[3] = 16'h8000; te[3] = {48'hFFFF_0000_0001, 16'h7FFF, 2'b00};
    tn[4] = 48'd12345;          td[4] = 16'h0000; te[4] = {48'hFFFF_FFFF_FFFF, 16'h0000, 2'b10};
    for (int i = 0; i < 5; i++) begin
      issue(tn[i], td[i], te[i], 49);
      repeat (49) tick();
    end
    issue(48'h8000_0000_0000, 16'hFFFF, {48'h8000_0000_0000, 16'h0, 2'b01}, 49);
    repeat (49) tick();

    // Stall with CE=0 and a start pulse while busy
    issue(48'd100, 16'd7, {48'd14, 16'd2, 2'b00}, 54);
    repeat (9) tick();
    DIVIDEND = 48'd5; DIVISOR = 16'd1; start = 1'b1;
    repeat (2) tick();
    start = 1'b0; CE = 1'b0;
    repeat (5) tick();
    CE = 1'b1;
    repeat (38) tick();
    CE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("done_hold_ce0", 66'(done), 66'h1);
    end
    CE = 1'b1;
    tick();
    chk("done_clear_after_hold", 66'(done), 66'h0);

    // Abort at edge 20 then a fresh op on the next edge
    issue(48'd100, 16'd7, {48'd14, 16'd2, 2'b00}, 49);
    repeat (19) tick();
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    chk("abort_outs", {busy, done, Q, R, DIV0, OVF}, 66'h0);
    issue(48'd1000, 16'hFFFD, {48'hFFFF_FFFF_FEB3, 16'd1, 2'b00}, 49);
    repeat (49) tick();

    // Back-to-back random ops with start held high
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r64 = {$urandom(), $urandom()};
      rn  = r64[47:0] >> $urandom_range(0, 47);
      if ($urandom_range(0, 1) == 1) rn = -rn;
      rd  = 16'($urandom());
      if ($urandom_range(0, 2) == 0) rd = 16'($urandom_range(1, 9));
      if ($urandom_range(0, 1) == 1) rd = -rd;
      if (i == 0) rd = 16'h0;
      if (i == 1) begin rn = 48'h8000_0000_0000; rd = 16'hFFFF; end
      if (i == 2) rd = 16'h8000;
      DIVIDEND = rn;
      DIVISOR  = rd;
      tick();
      exp_q.push_back(model(rn, rd));
      cyc_q.push_back(cyc + 49);
      repeat (49) tick();
    end
    start = 1'b0;

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d ops still pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
